// File: rtl/hilb_pkg.sv
// Shared types and sizing helpers for the Hilbert FIR tap controller.
// Default sizing below matches the production 31-tap FIR instance.
package hilb_pkg;

   function automatic int m_len_f(input int tap_len);
      return (tap_len + 4) / 4;
   endfunction

   localparam int TAP_LEN_DEF = 31;
   localparam int WIDTH_DEF   = 16;
   localparam int M_LEN_DEF   = m_len_f(TAP_LEN_DEF);

   typedef enum logic [2:0] {IDLE, LOAD, ARMED, SWAP, FLUSH} state_t;

   typedef logic signed [M_LEN_DEF-1:0][WIDTH_DEF-1:0] tap_bank_t;

endpackage

// File: rtl/cke_settle_cnt.sv
// Reloadable down-counter stepped by cke; done is registered and rises the cycle
// after the strobe that brings the count to zero. Load has priority over cke.
module cke_settle_cnt #(
   parameter int N = 31
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic cke,
   output logic done
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] RELOAD = CW'(N - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (load)
         cnt_nxt = RELOAD;
      else if (cke && (cnt != '0))
         cnt_nxt = cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= RELOAD;
         done <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         done <= (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/hilb_tap_ctrl.sv
// Loads a tap set into a shadow bank, swaps it live on a sample strobe and holds
// out_valid low until the FIR delay line has refilled; cfg_ready drops while armed/flushing.
module hilb_tap_ctrl
   import hilb_pkg::*;
#(
   parameter int TAP_LEN = TAP_LEN_DEF,
   parameter int M_LEN   = m_len_f(TAP_LEN),
   parameter int WIDTH   = WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cke,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [WIDTH-1:0]         cfg_data,
   input  logic                     cfg_last,
   output logic [M_LEN*WIDTH-1:0]   tap,
   output logic                     fir_rst,
   output logic                     fir_cke,
   output logic                     out_valid,
   output logic                     busy,
   output logic                     err_len
);

   localparam int IDX_W = $clog2(M_LEN + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M_LEN - 1);

   typedef logic signed [M_LEN-1:0][WIDTH-1:0] bank_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   bank_t            shadow;
   bank_t            tap_q;
   logic             accept;
   logic             swap;
   logic             settle_done;

   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      err_len   = 1'b0;
      swap      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = ~rst;
            accept    = cfg_valid & ~rst;
            if (accept) begin
               // a one-word set can never be complete since M_LEN >= 2
               if (cfg_last)
                  err_len = 1'b1;
               else
                  state_nxt = LOAD;
            end
         end
         LOAD: begin
            cfg_ready = ~rst;
            accept    = cfg_valid & ~rst;
            if (accept) begin
               if (cfg_last && (idx == IDX_LAST)) begin
                  state_nxt = ARMED;
               end else if (cfg_last || (idx == IDX_LAST)) begin
                  err_len   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         ARMED: begin
            if (cke) begin
               swap      = ~rst;
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (settle_done)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         shadow <= '0;
         tap_q  <= '0;
      end else begin
         state <= state_nxt;
         if (swap)
            tap_q <= shadow;
         if (accept) begin
            for (int k = 0; k < M_LEN; k++)
               if (idx == IDX_W'(k))
                  shadow[k] <= cfg_data;
            // idx is kept at zero whenever the set is not mid-load
            idx <= (state_nxt == LOAD) ? idx + IDX_W'(1) : '0;
         end
      end
   end

   cke_settle_cnt #(
      .N    (TAP_LEN)
   ) u_settle (
      .clk  (clk),
      .rst  (rst),
      .load (swap),
      .cke  (cke),
      .done (settle_done)
   );

   assign tap       = tap_q;
   assign fir_rst   = rst | swap;
   assign fir_cke   = cke;
   assign out_valid = settle_done;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hilb_tap_ctrl.sv
// Directed bench for hilb_tap_ctrl at TAP_LEN=7 (M_LEN=2), cke every 4th cycle.
module tb_hilb_tap_ctrl;

   logic        clk;
   logic        rst;
   logic        cke;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_data;
   logic        cfg_last;
   logic [31:0] tap;
   logic        fir_rst;
   logic        fir_cke;
   logic        out_valid;
   logic        busy;
   logic        err_len;

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int strobes = 0;
   bit cke_en  = 0;

   hilb_tap_ctrl #(
      .TAP_LEN   (7),
      .M_LEN     (2),
      .WIDTH     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cke       (cke),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .cfg_last  (cfg_last),
      .tap       (tap),
      .fir_rst   (fir_rst),
      .fir_cke   (fir_cke),
      .out_valid (out_valid),
      .busy      (busy),
      .err_len   (err_len)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // one clock; afterwards cke for the next edge is driven and outputs have settled
   task automatic step();
      if (cke) strobes++;
      @(posedge clk);
      #1;
      cyc++;
      cke = cke_en && (cyc % 4 == 0);
      #1;
   endtask

   task automatic send_word(input logic [15:0] d, input logic last, output logic err_seen);
      int  n;
      logic acc;
      cfg_data  = d;
      cfg_last  = last;
      cfg_valid = 1'b1;
      #1;
      n = 0;
      acc = 1'b0;
      err_seen = 1'b0;
      while (!acc && n < 100) begin
         acc = cfg_ready;
         err_seen = err_len;
         step();
         n++;
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      #1;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_word_timeout data=%h accepted=0 required=1", d);
      end
   endtask

   task automatic wait_cke();
      int n;
      n = 0;
      while (!cke && n < 100) begin
         step();
         n++;
      end
      if (!cke) begin
         checks++;
         errors++;
         $display("FAIL wait_cke_timeout cke=0 required=1");
      end
   endtask

   task automatic count_to_valid(output int n);
      int k;
      strobes = 0;
      k = 0;
      while (!out_valid && k < 300) begin
         step();
         k++;
      end
      n = strobes;
      if (!out_valid) n = -1;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; cke_en = 0; cke = 1'b0;
      cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
      repeat (3) step();
      checks++; if (tap !== 32'h0) begin errors++; $display("FAIL reset_tap got=%h exp=0", tap); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready); end
      checks++; if (fir_rst !== 1'b1) begin errors++; $display("FAIL reset_fir_rst got=%b exp=1", fir_rst); end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len got=%b exp=0", err_len); end
      rst = 1'b0; cke_en = 1;
      #1;
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_cfg_ready got=%b exp=1", cfg_ready); end
      checks++; if (fir_rst !== 1'b0) begin errors++; $display("FAIL idle_fir_rst got=%b exp=0", fir_rst); end
      count_to_valid(n);
      checks++; if (n !== 6) begin errors++; $display("FAIL reset_settle_strobes got=%0d exp=6", n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL settle_busy got=%b exp=0", busy); end
      checks++; if (tap !== 32'h0) begin errors++; $display("FAIL settle_tap got=%h exp=0", tap); end
   endtask

   task automatic test_load_swap();
      logic e;
      int n;
      send_word(16'h2000, 1'b0, e);
      send_word(16'h0AAA, 1'b1, e);
      checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL armed_busy_ready got=%b%b exp=10", busy, cfg_ready); end
      wait_cke();
      checks++; if (fir_rst !== 1'b1) begin errors++; $display("FAIL swap_fir_rst got=%b exp=1", fir_rst); end
      checks++; if (fir_cke !== 1'b1) begin errors++; $display("FAIL swap_fir_cke got=%b exp=1", fir_cke); end
      checks++; if (tap !== 32'h0) begin errors++; $display("FAIL pre_swap_tap got=%h exp=0", tap); end
      step();
      checks++; if (tap !== 32'h0AAA2000) begin errors++; $display("FAIL swap_tap got=%h exp=0aaa2000", tap); end
      checks++; if (fir_rst !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL post_swap got fir_rst=%b out_valid=%b exp 0 0", fir_rst, out_valid); end
      count_to_valid(n);
      checks++; if (n !== 6) begin errors++; $display("FAIL flush_strobes got=%0d exp=6", n); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_end_busy got=%b exp=1", busy); end
      step();
      checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL back_idle got busy=%b ready=%b exp 0 1", busy, cfg_ready); end
   endtask

   task automatic test_short_set();
      logic e;
      send_word(16'h1234, 1'b1, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL short_err_len got=%b exp=1", e); end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL short_err_width got=%b exp=0", err_len); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got=%b exp=0", busy); end
      checks++; if (tap !== 32'h0AAA2000) begin errors++; $display("FAIL short_tap got=%h exp=0aaa2000", tap); end
   endtask

   task automatic test_long_set();
      logic e;
      int   k;
      send_word(16'h1111, 1'b0, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL long_w1_err got=%b exp=0", e); end
      send_word(16'h2222, 1'b0, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL long_w2_err got=%b exp=1", e); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_idle got=%b exp=0", busy); end
      send_word(16'h7FFF, 1'b0, e);
      checks++; if (e !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL long_w3 got err=%b busy=%b exp 0 1", e, busy); end
      send_word(16'h8001, 1'b1, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL long_w4_err got=%b exp=0", e); end
      wait_cke();
      step();
      checks++; if (tap !== 32'h80017FFF) begin errors++; $display("FAIL long_tap got=%h exp=80017fff", tap); end
      k = 0;
      while (busy && k < 300) begin step(); k++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_return_idle got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      logic e;
      int   k;
      int   consumed;
      send_word(16'h0101, 1'b0, e);
      send_word(16'h0202, 1'b1, e);
      cfg_valid = 1'b1; cfg_data = 16'h5555; cfg_last = 1'b0;
      #1;
      consumed = 0;
      k = 0;
      while (busy && k < 300) begin
         if (cfg_ready) consumed++;
         step();
         k++;
      end
      cfg_valid = 1'b0;
      #1;
      checks++; if (consumed !== 0) begin errors++; $display("FAIL hold_consumed got=%0d exp=0", consumed); end
      checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL hold_idle got busy=%b ready=%b exp 0 1", busy, cfg_ready); end
      checks++; if (tap !== 32'h02020101) begin errors++; $display("FAIL hold_tap got=%h exp=02020101", tap); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid got=%b exp=1", out_valid); end
   endtask

   task automatic test_rst_mid();
      logic e;
      int   n;
      send_word(16'h1111, 1'b0, e);
      rst = 1'b1;
      #1;
      checks++; if (cfg_ready !== 1'b0 || fir_rst !== 1'b1) begin errors++; $display("FAIL rst_load_comb got ready=%b fir_rst=%b exp 0 1", cfg_ready, fir_rst); end
      step();
      checks++; if (busy !== 1'b0 || tap !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_load got busy=%b tap=%h ov=%b exp 0 0 0", busy, tap, out_valid); end
      rst = 1'b0;
      step();
      send_word(16'h0303, 1'b0, e);
      send_word(16'h0404, 1'b1, e);
      wait_cke();
      step();
      checks++; if (busy !== 1'b1 || tap !== 32'h04040303) begin errors++; $display("FAIL pre_rst_flush got busy=%b tap=%h exp 1 04040303", busy, tap); end
      rst = 1'b1;
      step();
      checks++; if (busy !== 1'b0 || tap !== 32'h0 || out_valid !== 1'b0 || err_len !== 1'b0) begin errors++; $display("FAIL rst_flush got busy=%b tap=%h ov=%b err=%b exp 0 0 0 0", busy, tap, out_valid, err_len); end
      rst = 1'b0;
      step();
      send_word(16'h0505, 1'b0, e);
      send_word(16'h0606, 1'b1, e);
      wait_cke();
      step();
      checks++; if (tap !== 32'h06060505) begin errors++; $display("FAIL reload_tap got=%h exp=06060505", tap); end
      count_to_valid(n);
      checks++; if (n !== 6) begin errors++; $display("FAIL reload_strobes got=%0d exp=6", n); end
   endtask

   initial begin
      test_reset();
      test_load_swap();
      test_short_set();
      test_long_set();
      test_back_to_back();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
